// File: rtl/uart_rx_sink.sv
// uart_rx_sink: oversampling 8N1 UART receiver with a small output FIFO
// and single-cycle framing-error / overflow pulses.
module uart_rx_sink #(
    parameter int unsigned BAUD_DIV   = 434,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          rx_i,
    output logic [7:0]                    data_o,
    output logic                          valid_o,
    input  logic                          ready_i,
    output logic                          frame_err_o,
    output logic                          overflow_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   level_o
);

    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam int unsigned CW        = AW + 1;
    localparam logic [15:0] HALF_LAST = 16'(BAUD_DIV / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    logic          rx_s1, rx_s2;
    state_t        state, state_n;
    logic [15:0]   cnt, cnt_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          push_c, ferr_c;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          pop, full, accept;

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= rx_i;
            rx_s2 <= rx_s1;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
        end
    end

    // Deframing: half-bit wait to the start centre, then full-bit steps to each centre.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        push_c    = 1'b0;
        ferr_c    = 1'b0;
        unique case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (!rx_s2) state_n = S_START;
            end
            S_START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n     = '0;
                    bit_idx_n = '0;
                    state_n   = rx_s2 ? S_IDLE : S_DATA;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n            = '0;
                    shift_n[bit_idx] = rx_s2;
                    if (bit_idx == 3'd7) state_n = S_STOP;
                    else bit_idx_n = bit_idx + 3'd1;
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rx_s2) begin
                        push_c  = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        ferr_c  = 1'b1;
                        state_n = S_BREAK;
                    end
                end else begin
                    cnt_n = cnt + 16'd1;
                end
            end
            S_BREAK: begin
                cnt_n = '0;
                if (rx_s2) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    assign pop    = valid_o && ready_i;
    assign full   = (count == CW'(FIFO_DEPTH));
    assign accept = push_c && (!full || pop);

    // FIFO storage; a full FIFO with a simultaneous pop still accepts the byte.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
        end else if (accept) begin
            mem[wr_ptr] <= shift;
        end
    end

    // FIFO pointers, occupancy and event pulses.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            frame_err_o <= 1'b0;
            overflow_o  <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            if (accept && !pop)      count <= count + CW'(1);
            else if (!accept && pop) count <= count - CW'(1);
            frame_err_o <= ferr_c;
            overflow_o  <= push_c && full && !pop;
        end
    end

    assign data_o  = mem[rd_ptr];
    assign valid_o = (count != '0);
    assign level_o = count;
    assign busy_o  = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_sink.sv
// Directed self-checking bench for uart_rx_sink (BAUD_DIV=16, FIFO_DEPTH=4).
module tb_uart_rx_sink;

    localparam int unsigned BD = 16;
    localparam int unsigned FD = 4;

    logic       clk_i   = 1'b0;
    logic       rst_ni  = 1'b0;
    logic       rx_i    = 1'b1;
    logic       ready_i = 1'b0;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_err_o;
    logic       overflow_o;
    logic       busy_o;
    logic [2:0] level_o;

    int n_checks = 0;
    int n_fail   = 0;

    int cyc       = 0;
    int ferr_cnt  = 0;
    int ovf_cnt   = 0;
    int ovf_cyc   = 0;
    int vrise_cyc = 0;
    logic valid_d = 1'b0;
    logic [7:0] popq [$];

    logic [7:0] exp_b2b [4] = '{8'h41, 8'h0A, 8'hFF, 8'h00};
    logic [7:0] exp_ovf [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    uart_rx_sink #(.BAUD_DIV(BD), .FIFO_DEPTH(FD)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rx_i        (rx_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .frame_err_o (frame_err_o),
        .overflow_o  (overflow_o),
        .busy_o      (busy_o),
        .level_o     (level_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Event monitor sampled on the falling edge.
    always @(negedge clk_i) begin
        valid_d <= valid_o;
        if (rst_ni) begin
            if (valid_o && ready_i) popq.push_back(data_o);
            if (frame_err_o) ferr_cnt <= ferr_cnt + 1;
            if (overflow_o) begin
                ovf_cnt <= ovf_cnt + 1;
                ovf_cyc <= cyc;
            end
            if (valid_o && !valid_d) vrise_cyc <= cyc;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    // Drives one frame starting now; leaves rx_i at the stop-bit level.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_i = 1'b0;
        wait_cycles(BD);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            wait_cycles(BD);
        end
        rx_i = stop;
        wait_cycles(BD);
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        repeat (3) @(negedge clk_i);
        n_checks++; if (data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data got %h want 00", data_o); end
        n_checks++; if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_o); end
        n_checks++; if (level_o !== 3'd0) begin n_fail++; $display("FAIL reset_level got %0d want 0", level_o); end
        n_checks++; if ({busy_o, frame_err_o, overflow_o} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags got %b want 000", {busy_o, frame_err_o, overflow_o});
        end
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        wait_cycles(4);
    endtask

    task automatic test_single;
        int t0;
        ready_i = 1'b1;
        popq.delete();
        t0 = cyc;
        send_byte(8'h55, 1'b1);
        wait_cycles(5);
        n_checks++; if (popq.size() !== 1) begin n_fail++; $display("FAIL single_count got %0d want 1", popq.size()); end
        else begin
            n_checks++; if (popq[0] !== 8'h55) begin n_fail++; $display("FAIL single_data got %h want 55", popq[0]); end
        end
        n_checks++; if ((vrise_cyc - t0) < 154 || (vrise_cyc - t0) > 156) begin
            n_fail++; $display("FAIL single_latency got %0d want 155", vrise_cyc - t0);
        end
        n_checks++; if (level_o !== 3'd0) begin n_fail++; $display("FAIL single_level got %0d want 0", level_o); end
    endtask

    task automatic test_back_to_back;
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send_byte(exp_b2b[i], 1'b1);
            n_checks++; if (level_o !== 3'(i + 1)) begin
                n_fail++; $display("FAIL b2b_level[%0d] got %0d want %0d", i, level_o, i + 1);
            end
        end
        ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            n_checks++; if (valid_o !== 1'b1 || data_o !== exp_b2b[i]) begin
                n_fail++; $display("FAIL b2b_drain[%0d] got v=%b d=%h want v=1 d=%h", i, valid_o, data_o, exp_b2b[i]);
            end
        end
        @(posedge clk_i); #1;
        ready_i = 1'b0;
        n_checks++; if (level_o !== 3'd0) begin n_fail++; $display("FAIL b2b_empty got %0d want 0", level_o); end
    endtask

    task automatic test_overflow;
        int t0, o0;
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) send_byte(exp_ovf[i], 1'b1);
        n_checks++; if (level_o !== 3'd4) begin n_fail++; $display("FAIL ovf_full got %0d want 4", level_o); end
        o0 = ovf_cnt;
        t0 = cyc;
        send_byte(8'h7E, 1'b1);
        wait_cycles(3);
        n_checks++; if (ovf_cnt - o0 !== 1) begin n_fail++; $display("FAIL ovf_pulses got %0d want 1", ovf_cnt - o0); end
        n_checks++; if ((ovf_cyc - t0) < 154 || (ovf_cyc - t0) > 156) begin
            n_fail++; $display("FAIL ovf_timing got %0d want 155", ovf_cyc - t0);
        end
        n_checks++; if (level_o !== 3'd4) begin n_fail++; $display("FAIL ovf_level got %0d want 4", level_o); end
        popq.delete();
        ready_i = 1'b1;
        wait_cycles(8);
        n_checks++; if (popq.size() !== 4) begin n_fail++; $display("FAIL ovf_drain_count got %0d want 4", popq.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_checks++; if (popq[i] !== exp_ovf[i]) begin
                    n_fail++; $display("FAIL ovf_drain[%0d] got %h want %h", i, popq[i], exp_ovf[i]);
                end
            end
        end
        ready_i = 1'b0;
    endtask

    task automatic test_glitch;
        int f0;
        ready_i = 1'b1;
        popq.delete();
        f0 = ferr_cnt;
        rx_i = 1'b0;
        wait_cycles(4);
        rx_i = 1'b1;
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_high got %b want 1", busy_o); end
        wait_cycles(10);
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL glitch_busy_low got %b want 0", busy_o); end
        n_checks++; if (popq.size() !== 0 || ferr_cnt !== f0) begin
            n_fail++; $display("FAIL glitch_quiet got bytes=%0d ferr=%0d want 0 0", popq.size(), ferr_cnt - f0);
        end
    endtask

    task automatic test_frame_error;
        int f0;
        ready_i = 1'b1;
        popq.delete();
        f0 = ferr_cnt;
        send_byte(8'hA5, 1'b0);
        wait_cycles(40);
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL break_busy got %b want 1", busy_o); end
        n_checks++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL break_ferr got %0d want 1", ferr_cnt - f0); end
        rx_i = 1'b1;
        wait_cycles(BD);
        n_checks++; if (busy_o !== 1'b0) begin n_fail++; $display("FAIL break_release got %b want 0", busy_o); end
        send_byte(8'h3C, 1'b1);
        wait_cycles(5);
        n_checks++; if (popq.size() !== 1) begin n_fail++; $display("FAIL ferr_bytes got %0d want 1", popq.size()); end
        else begin
            n_checks++; if (popq[0] !== 8'h3C) begin n_fail++; $display("FAIL ferr_next got %h want 3c", popq[0]); end
        end
        n_checks++; if (ferr_cnt - f0 !== 1) begin n_fail++; $display("FAIL ferr_total got %0d want 1", ferr_cnt - f0); end
    endtask

    task automatic test_mid_reset;
        int f0, o0;
        ready_i = 1'b0;
        send_byte(8'h66, 1'b1);
        wait_cycles(2);
        n_checks++; if (level_o !== 3'd1) begin n_fail++; $display("FAIL mrst_pre_level got %0d want 1", level_o); end
        rx_i = 1'b0; wait_cycles(BD);
        rx_i = 1'b1; wait_cycles(BD);
        rx_i = 1'b0; wait_cycles(BD / 2);
        n_checks++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL mrst_busy got %b want 1", busy_o); end
        rst_ni = 1'b0;
        @(negedge clk_i);
        n_checks++; if ({valid_o, busy_o, frame_err_o, overflow_o} !== 4'b0000 || data_o !== 8'h00 || level_o !== 3'd0) begin
            n_fail++; $display("FAIL mrst_outputs got v=%b b=%b fe=%b ov=%b d=%h l=%0d want all 0",
                               valid_o, busy_o, frame_err_o, overflow_o, data_o, level_o);
        end
        @(posedge clk_i); #1;
        rx_i = 1'b1;
        wait_cycles(3);
        rst_ni = 1'b1;
        wait_cycles(20);
        ready_i = 1'b1;
        popq.delete();
        f0 = ferr_cnt;
        o0 = ovf_cnt;
        send_byte(8'h12, 1'b1);
        wait_cycles(5);
        n_checks++; if (popq.size() !== 1) begin n_fail++; $display("FAIL mrst_bytes got %0d want 1", popq.size()); end
        else begin
            n_checks++; if (popq[0] !== 8'h12) begin n_fail++; $display("FAIL mrst_data got %h want 12", popq[0]); end
        end
        n_checks++; if (ferr_cnt !== f0 || ovf_cnt !== o0) begin
            n_fail++; $display("FAIL mrst_pulses got fe=%0d ov=%0d want 0 0", ferr_cnt - f0, ovf_cnt - o0);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_glitch();
        test_frame_error();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_sink.md
Name: uart_rx_sink

Overview:
- Serial receive stage directly downstream of the SoC top-level UART `tx` pin.
- Used in the FPGA simulation bench as the console sink, and reusable as a synthesizable receiver.
- Oversamples the line, deframes 8N1 characters LSB-first, and buffers received bytes in a small FIFO with a valid/ready output.
- Reports framing errors and overflow as single-cycle pulses.

Parameters:
- BAUD_DIV, 434, clock cycles per bit (50 MHz / 115200); legal range 4..65535.
- FIFO_DEPTH, 8, output FIFO entries; power of two, minimum 2.

Ports:
- clk_i  in  1  single clock.
- rst_ni  in  1  asynchronous, active-low reset.
- rx_i  in  1  serial line; idle high; asynchronous to clk_i.
- data_o  out  8  head-of-FIFO byte.
- valid_o  out  1  FIFO not empty.
- ready_i  in  1  consumer accepts data_o when valid_o && ready_i.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- overflow_o  out  1  one-cycle pulse: byte dropped because FIFO full.
- busy_o  out  1  receiver FSM not in IDLE.
- level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset:
  - Asynchronous, active-low on rst_ni; all flops clear immediately.
  - Sync flops reset to 1, FSM to IDLE, FIFO empty.
  - All outputs reset to 0.
  - Assertion mid-frame discards the partial byte; no pulse is generated.
- Input: rx_i passes through a 2-flop synchronizer. All references to "rx" below mean the synchronized value.
- Bit counter: cnt (16 bit) counts clock cycles within a bit.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - rx==0 -> START, cnt=0.
- START:
  - When cnt==BAUD_DIV/2-1 (integer division), sample rx.
  - rx==1: glitch; go to IDLE with no output.
  - rx==0: go to DATA, cnt=0, bit index=0.
- DATA:
  - When cnt==BAUD_DIV-1, sample rx into shift[bit index] (LSB first) and reset cnt.
  - After bit index 7 is sampled, go to STOP.
- STOP:
  - When cnt==BAUD_DIV-1, sample rx.
  - rx==1: push the byte and go to IDLE.
  - rx==0: assert frame_err_o for 1 cycle, drop the byte, go to BREAK.
- BREAK: remain until rx==1, then go to IDLE. A continuous low line therefore produces exactly one frame_err_o.
- Timing:
  - Sample points fall at bit centres.
  - The FSM re-enters IDLE in the stop-bit centre cycle, so back-to-back frames with a single stop bit are received.
- Push latency:
  - The byte is written to the FIFO on the clock edge ending the stop-sample cycle.
  - valid_o rises the following cycle if the FIFO was empty.
  - No combinational path from rx_i to any output.
- FIFO:
  - Registered read pointer, write pointer and count; first-word data_o is valid whenever valid_o==1.
  - Pop occurs when valid_o && ready_i.
  - Push when full and no pop in the same cycle: the byte is dropped, overflow_o pulses 1 cycle, FIFO contents are unchanged.
  - Push when full with a pop in the same cycle: accepted, no overflow, level unchanged.
  - Push and pop when empty: the pop is not possible because valid_o==0; the push proceeds.
  - Pointers wrap modulo FIFO_DEPTH.
  - level_o equals the count, range 0..FIFO_DEPTH.
- data_o is held stable while valid_o && !ready_i.
- busy_o=1 in START, DATA, STOP and BREAK.
- frame_err_o and overflow_o may pulse in the same cycle only if both conditions arise together. The design prevents this because a framing error never pushes.

Test Plan:
- BAUD_DIV=16, FIFO_DEPTH=4, reset then send 0x55 8N1, ready_i=1:
  - valid_o pulses once with data_o=0x55.
  - Push occurs 2+8+16*9 cycles (±1) after the start edge.
  - level_o returns to 0.
- Send 0x41,0x0A,0xFF,0x00 back-to-back with ready_i=0:
  - level_o steps 1..4.
  - Then raising ready_i yields 0x41,0x0A,0xFF,0x00 in order, one per cycle.
- With FIFO full (4 bytes) and ready_i=0, send 0x7E:
  - overflow_o pulses once one cycle after the stop sample.
  - Contents unchanged; draining yields the original 4 bytes only.
- Drive rx low for 4 cycles then high (glitch shorter than BAUD_DIV/2):
  - FSM returns to IDLE.
  - No valid_o, no frame_err_o, busy_o drops within 8+2 cycles.
- Send 0xA5 with the stop bit forced low, hold low for 40 cycles, then release and send 0x3C:
  - One frame_err_o pulse; 0xA5 is not pushed.
  - BREAK is held until release; 0x3C is then received correctly.
- Assert rst_ni low mid-DATA of 0x99, release, send 0x12:
  - All outputs read 0 while reset is low.
  - Only 0x12 is received; no error pulses.
